// File: rtl/rename_pkg.sv
// Shared types and helpers for the rename bundle sequencer.
package rename_pkg;

  typedef enum logic {NORMAL = 1'b0, SPLIT = 1'b1} seq_state_t;

  localparam int NUM_CHECKPOINTS_DEFAULT = 8;
  localparam int CPW = $clog2(NUM_CHECKPOINTS_DEFAULT + 1);

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rename_prefix_select.sv
// Combinational in-order lane picker: accepts pending lanes from lane 0 upward
// until the next branch would push the checkpoint count past the limit.
module rename_prefix_select
  import rename_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LIMIT_W = 4,
  localparam int LANE_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   pending,
  input  logic [WIDTH-1:0]   is_branch,
  input  logic [LIMIT_W-1:0] limit,
  output logic [WIDTH-1:0]   issue_valid,
  output logic [LANE_W-1:0]  first_br_lane
);

  logic [WIDTH-1:0] pend_br;
  logic [WIDTH-1:0] seen;

  assign pend_br = pending & is_branch;

  // Branch count is monotonic along the lanes, so once it exceeds the limit
  // every later lane (branch or not) is held back as well.
  always_comb begin
    issue_valid   = '0;
    first_br_lane = '0;
    seen          = '0;
    for (int i = 0; i < WIDTH; i++) begin
      seen[i] = 1'b1;
      if (pending[i] && (popcount(64'(pend_br & seen)) <= 32'(limit))) begin
        issue_valid[i] = 1'b1;
      end
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (issue_valid[i] && is_branch[i]) begin
        first_br_lane = LANE_W'(i);
      end
    end
  end

endmodule

// File: rtl/rename_bundle_sequencer.sv
// Splits a decode group into rename sub-bundles bounded by checkpoint budget.
// Optional perf counters are enabled by defining RENAME_SEQ_PERF_EN.
module rename_bundle_sequencer
  import rename_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MAX_BR          = 1,
  parameter int NUM_CHECKPOINTS = 8,
  localparam int FREE_W = $clog2(NUM_CHECKPOINTS + 1),
  localparam int LANE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_stall,
  input  logic              res_stall,
  input  logic              if_recall,
  input  logic [WIDTH-1:0]  in_valid,
  input  logic [WIDTH-1:0]  in_is_branch,
  input  logic [FREE_W-1:0] free_cp,
  output logic [WIDTH-1:0]  issue_valid,
  output logic [WIDTH-1:0]  make_checkpoint,
  output logic [LANE_W-1:0] first_br_lane,
  output logic              decode_hold,
  output logic              split_active
`ifdef RENAME_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_split_cycles,
  output logic [31:0]       perf_cp_starve,
  output logic [31:0]       perf_groups
`endif
);

  logic [WIDTH-1:0]  consumed;
  logic [WIDTH-1:0]  consumed_nxt;
  logic [WIDTH-1:0]  pending;
  logic [WIDTH-1:0]  sel_valid;
  logic [WIDTH-1:0]  next_mask;
  logic [LANE_W-1:0] sel_first;
  logic [FREE_W-1:0] limit;
  logic              advance;
  logic              group_done;
  seq_state_t        state;

  assign pending    = in_valid & ~consumed;
  assign state      = (consumed == '0) ? NORMAL : SPLIT;
  assign advance    = ~ext_stall & ~res_stall & ~if_recall & ~reset;
  assign limit      = (int'(free_cp) > MAX_BR) ? FREE_W'(MAX_BR) : free_cp;
  // Invalid lanes count as already consumed so gaps never stall completion.
  assign next_mask  = consumed | sel_valid | ~in_valid;
  assign group_done = advance & (&next_mask);

  rename_prefix_select #(
    .WIDTH   (WIDTH),
    .LIMIT_W (FREE_W)
  ) u_select (
    .pending       (pending),
    .is_branch     (in_is_branch),
    .limit         (limit),
    .issue_valid   (sel_valid),
    .first_br_lane (sel_first)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      consumed <= '0;
    end else begin
      consumed <= consumed_nxt;
    end
  end

  always_comb begin
    consumed_nxt = consumed;
    if (if_recall) begin
      consumed_nxt = '0;
    end else if (advance) begin
      consumed_nxt = group_done ? '0 : next_mask;
    end
  end

  // Recall flushes decode, so neither issue nor hold is asserted that cycle.
  always_comb begin
    issue_valid     = '0;
    make_checkpoint = '0;
    first_br_lane   = '0;
    decode_hold     = 1'b0;
    split_active    = 1'b0;
    if (!reset) begin
      split_active = (state == SPLIT);
      if (!if_recall) begin
        issue_valid     = sel_valid;
        make_checkpoint = sel_valid & in_is_branch;
        first_br_lane   = sel_first;
        decode_hold     = advance ? ~(&next_mask) : (|pending);
      end
    end
  end

`ifdef RENAME_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_split_cycles <= '0;
      perf_cp_starve    <= '0;
      perf_groups       <= '0;
    end else begin
      if (advance && decode_hold && (perf_split_cycles != '1)) begin
        perf_split_cycles <= perf_split_cycles + 32'd1;
      end
      if (!if_recall && (|pending) && (sel_valid == '0) && (perf_cp_starve != '1)) begin
        perf_cp_starve <= perf_cp_starve + 32'd1;
      end
      if (group_done && (perf_groups != '1)) begin
        perf_groups <= perf_groups + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rename_bundle_sequencer.sv
// Scoreboard bench for rename_bundle_sequencer: a 4-lane/2-branch instance and
// a 2-lane/1-branch instance that reproduces the legacy double-branch trace.
module tb_rename_bundle_sequencer;

  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ext_stall = 1'b0;
  logic          res_stall = 1'b0;
  logic          if_recall = 1'b0;
  logic [3:0]    v4 = '0;
  logic [3:0]    b4 = '0;
  logic [1:0]    v2 = '0;
  logic [1:0]    b2 = '0;
  logic [FW-1:0] free_cp = '0;

  logic [3:0] iv4, mc4;
  logic [1:0] fb4;
  logic       hold4, split4;
  logic [1:0] iv2, mc2;
  logic       fb2;
  logic       hold2, split2;

  typedef struct {
    int         sel;
    logic [3:0] iv;
    logic [3:0] mc;
    logic [1:0] fb;
    logic       hold;
    logic       split;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rename_bundle_sequencer #(.WIDTH(4), .MAX_BR(2), .NUM_CHECKPOINTS(8)) dut4 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .res_stall(res_stall),
    .if_recall(if_recall), .in_valid(v4), .in_is_branch(b4), .free_cp(free_cp),
    .issue_valid(iv4), .make_checkpoint(mc4), .first_br_lane(fb4),
    .decode_hold(hold4), .split_active(split4)
  );

  rename_bundle_sequencer #(.WIDTH(2), .MAX_BR(1), .NUM_CHECKPOINTS(8)) dut2 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .res_stall(res_stall),
    .if_recall(if_recall), .in_valid(v2), .in_is_branch(b2), .free_cp(free_cp),
    .issue_valid(iv2), .make_checkpoint(mc2), .first_br_lane(fb2),
    .decode_hold(hold2), .split_active(split2)
  );

  task automatic applyStimulus(input int sel, input logic rst, input logic ext,
                               input logic res, input logic rec,
                               input logic [3:0] v, input logic [3:0] b,
                               input logic [3:0] free,
                               input logic [3:0] iv, input logic [3:0] mc,
                               input logic [1:0] fb, input logic hold,
                               input logic split, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    ext_stall = ext;
    res_stall = res;
    if_recall = rec;
    free_cp   = free;
    if (sel == 4) begin
      v4 = v;  b4 = b;  v2 = '0;  b2 = '0;
    end else begin
      v2 = v[1:0];  b2 = b[1:0];  v4 = '0;  b4 = '0;
    end
    e.sel = sel;  e.iv = iv;  e.mc = mc;  e.fb = fb;
    e.hold = hold;  e.split = split;  e.name = name;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] aiv, amc;
    logic [1:0] afb;
    logic       ah, as;
    if (e.sel == 4) begin
      aiv = iv4;  amc = mc4;  afb = fb4;  ah = hold4;  as = split4;
    end else begin
      aiv = {2'b00, iv2};  amc = {2'b00, mc2};  afb = {1'b0, fb2};
      ah = hold2;  as = split2;
    end
    checks++;
    if ({aiv, amc, afb, ah, as} !== {e.iv, e.mc, e.fb, e.hold, e.split}) begin
      failures++;
      $display("[TB] FAIL %s: got iv=%b mc=%b fb=%0d hold=%b split=%b, want iv=%b mc=%b fb=%0d hold=%b split=%b",
               e.name, aiv, amc, afb, ah, as, e.iv, e.mc, e.fb, e.hold, e.split);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    //               sel rst ext res rec valid    branch   free   iv       mc       fb  hold split
    applyStimulus(4, 1, 0, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset_a");
    applyStimulus(4, 1, 0, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset_b");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 4'b0000, 2'd0, 0, 0, "no_branch");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0101, 4'd1, 4'b0011, 4'b0001, 2'd0, 1, 0, "two_br_c1");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0101, 4'd1, 4'b1100, 4'b0100, 2'd2, 0, 1, "two_br_c2");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0111, 4'd8, 4'b0011, 4'b0011, 2'd0, 1, 0, "maxbr_c1");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0111, 4'd8, 4'b1100, 4'b0100, 2'd2, 0, 1, "maxbr_c2");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0001, 4'b0001, 2'd0, 1, 0, "br4_c1");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0010, 4'b0010, 2'd1, 1, 1, "br4_c2");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0100, 4'b0100, 2'd2, 1, 1, "br4_c3");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b1000, 4'b1000, 2'd3, 0, 1, "br4_c4");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0010, 4'd0, 4'b0001, 4'b0000, 2'd0, 1, 0, "starve_c1");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0010, 4'd1, 4'b1110, 4'b0010, 2'd1, 0, 1, "starve_c2");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0001, 4'd0, 4'b0000, 4'b0000, 2'd0, 1, 0, "head_block_a");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0001, 4'd0, 4'b0000, 4'b0000, 2'd0, 1, 0, "head_block_b");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0001, 4'd1, 4'b1111, 4'b0001, 2'd0, 0, 0, "head_release");
    applyStimulus(4, 0, 0, 0, 0, 4'b1010, 4'b0000, 4'd8, 4'b1010, 4'b0000, 2'd0, 0, 0, "gap");
    applyStimulus(4, 0, 0, 0, 0, 4'b1101, 4'b1001, 4'd8, 4'b1101, 4'b1001, 2'd0, 0, 0, "gap_br");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0001, 4'b0001, 2'd0, 1, 0, "stall_c1");
    applyStimulus(4, 0, 1, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0010, 4'b0010, 2'd1, 1, 1, "stall_ext_a");
    applyStimulus(4, 0, 1, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0010, 4'b0010, 2'd1, 1, 1, "stall_ext_b");
    applyStimulus(4, 0, 0, 1, 0, 4'b1111, 4'b1111, 4'd1, 4'b0010, 4'b0010, 2'd1, 1, 1, "stall_res");
    applyStimulus(4, 0, 1, 0, 1, 4'b1111, 4'b1111, 4'd1, 4'b0000, 4'b0000, 2'd0, 0, 1, "recall");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 4'b0000, 2'd0, 0, 0, "post_recall");
    applyStimulus(4, 0, 1, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 4'b0000, 2'd0, 1, 0, "stall_fresh");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'd8, 4'b1111, 4'b0000, 2'd0, 0, 0, "fresh_go");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0001, 4'b0001, 2'd0, 1, 0, "rst_mid_c1");
    applyStimulus(4, 1, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_mid");
    applyStimulus(4, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'd1, 4'b0001, 4'b0001, 2'd0, 1, 0, "rst_fresh");
    // Legacy 2-wide, one checkpoint per cycle.
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0001, 4'b0001, 2'd0, 1, 0, "w2_br1");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0010, 4'b0010, 2'd1, 0, 1, "w2_br2");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0001, 4'b0001, 2'd0, 1, 0, "w2_again");
    applyStimulus(2, 1, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0000, 4'b0000, 2'd0, 0, 0, "w2_reset");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0001, 4'b0001, 2'd0, 1, 0, "w2_fresh");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0011, 4'd8, 4'b0010, 4'b0010, 2'd1, 0, 1, "w2_fresh2");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0001, 4'd8, 4'b0011, 4'b0001, 2'd0, 0, 0, "w2_br_lo");
    applyStimulus(2, 0, 0, 0, 0, 4'b0011, 4'b0010, 4'd8, 4'b0011, 4'b0010, 2'd1, 0, 0, "w2_br_hi");
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
